// File: rtl/matrix_op_sequencer.sv
// Sequencer between the result RAM and the matrix coprocessor: fetches size/A/B, runs the op,
// writes the result back and shows it on the LEDs. Define MATSEQ_LED_SCAN_EN to scan the full result.
module matrix_op_sequencer #(
    parameter int DATA_W    = 256,
    parameter int ADDR_W    = 8,
    parameter int SIZE_W    = 3,
    parameter int LED_W     = 8,
    parameter int RD_LAT    = 1,
    parameter int TICK_DIV  = 25_000_000,
    parameter int TIMEOUT   = 1024,
    parameter int SIZE_ADDR = 0,
    parameter int A_ADDR    = 1,
    parameter int B_ADDR    = 2,
    parameter int C_ADDR    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sw,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [SIZE_W-1:0] op_size,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic              op_start,
    input  logic              op_done,
    input  logic [DATA_W-1:0] op_result,
    output logic              busy,
    output logic              err,
    output logic [LED_W-1:0]  leds
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    if (RD_LAT < 1 || RD_LAT > 3 || TICK_DIV < 2 || (DATA_W % LED_W) != 0 || LED_W < 6)
    begin : g_param_check
        $error("matrix_op_sequencer: illegal parameter combination");
    end

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_RD_SIZE   = 4'd1,
        S_RD_A      = 4'd2,
        S_RD_B      = 4'd3,
        S_START     = 4'd4,
        S_WAIT_DONE = 4'd5,
        S_WRITE     = 4'd6,
        S_SCAN      = 4'd7,
        S_ERR       = 4'd8
    } state_t;

    state_t            state;
    state_t            nxt;
    logic              sw_q;
    logic              sw_qq;
    logic              start;
    logic [1:0]        rd_cnt;
    logic              rd_done;
    logic [WD_W-1:0]   wd_cnt;
    logic [DATA_W-1:0] res_q;
    logic              cap_size;
    logic              cap_a;
    logic              cap_b;
    logic              cap_res;
    logic              rd_inc;
    logic              wd_inc;
    logic              set_err;
    logic              clr_err;

    // Two-flop synchroniser; only the rising edge of the switch starts a run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_q  <= 1'b0;
            sw_qq <= 1'b0;
        end else begin
            sw_q  <= sw;
            sw_qq <= sw_q;
        end
    end

    assign start   = sw_q & ~sw_qq;
    assign rd_done = (rd_cnt == 2'(RD_LAT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt       = state;
        cap_size  = 1'b0;
        cap_a     = 1'b0;
        cap_b     = 1'b0;
        cap_res   = 1'b0;
        rd_inc    = 1'b0;
        wd_inc    = 1'b0;
        set_err   = 1'b0;
        clr_err   = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        ram_we    = 1'b0;
        op_start  = 1'b0;
        busy      = 1'b0;
        case (state)
            S_IDLE, S_SCAN, S_ERR: begin
                if (start) begin
                    nxt     = S_RD_SIZE;
                    clr_err = 1'b1;
                end
            end
            S_RD_SIZE: begin
                busy     = 1'b1;
                ram_addr = ADDR_W'(SIZE_ADDR);
                if (rd_done) begin
                    cap_size = 1'b1;
                    if (ram_rdata[SIZE_W-1:0] == '0) begin
                        nxt     = S_ERR;
                        set_err = 1'b1;
                    end else begin
                        nxt = S_RD_A;
                    end
                end else begin
                    rd_inc = 1'b1;
                end
            end
            S_RD_A: begin
                busy     = 1'b1;
                ram_addr = ADDR_W'(A_ADDR);
                if (rd_done) begin
                    cap_a = 1'b1;
                    nxt   = S_RD_B;
                end else begin
                    rd_inc = 1'b1;
                end
            end
            S_RD_B: begin
                busy     = 1'b1;
                ram_addr = ADDR_W'(B_ADDR);
                if (rd_done) begin
                    cap_b = 1'b1;
                    nxt   = S_START;
                end else begin
                    rd_inc = 1'b1;
                end
            end
            S_START: begin
                busy     = 1'b1;
                op_start = 1'b1;
                nxt      = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                busy = 1'b1;
                // A done arriving on the last allowed clock still completes normally.
                if (op_done) begin
                    cap_res = 1'b1;
                    nxt     = S_WRITE;
                end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                    nxt     = S_ERR;
                    set_err = 1'b1;
                end else begin
                    wd_inc = 1'b1;
                end
            end
            S_WRITE: begin
                busy      = 1'b1;
                ram_addr  = ADDR_W'(C_ADDR);
                ram_wdata = res_q;
                ram_we    = 1'b1;
                nxt       = S_SCAN;
            end
            default: nxt = S_IDLE;
        endcase
    end

    // Counters fall back to zero whenever they are not advancing, so every state entry starts clean.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt  <= '0;
            wd_cnt  <= '0;
            op_size <= '0;
            op_a    <= '0;
            op_b    <= '0;
            res_q   <= '0;
            err     <= 1'b0;
        end else begin
            rd_cnt <= rd_inc ? rd_cnt + 2'd1 : 2'd0;
            wd_cnt <= wd_inc ? wd_cnt + WD_W'(1) : '0;
            if (cap_size) op_size <= ram_rdata[SIZE_W-1:0];
            if (cap_a)    op_a    <= ram_rdata;
            if (cap_b)    op_b    <= ram_rdata;
            if (cap_res)  res_q   <= op_result;
            if (set_err) begin
                err <= 1'b1;
            end else if (clr_err) begin
                err <= 1'b0;
            end
        end
    end

`ifdef MATSEQ_LED_SCAN_EN
    localparam int NSTEP  = DATA_W / LED_W;
    localparam int IDX_W  = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam int TICK_W = $clog2(TICK_DIV);

    logic [TICK_W-1:0] tick_cnt;
    logic [IDX_W-1:0]  idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
            idx      <= '0;
            leds     <= '0;
        end else if (set_err) begin
            leds <= '1;
        end else if (state == S_WRITE) begin
            tick_cnt <= '0;
            idx      <= '0;
        end else if (state == S_SCAN) begin
            if (tick_cnt == TICK_W'(TICK_DIV - 1)) begin
                tick_cnt <= '0;
                leds     <= res_q[int'(idx) * LED_W +: LED_W];
                idx      <= (idx == IDX_W'(NSTEP - 1)) ? '0 : idx + IDX_W'(1);
            end else begin
                tick_cnt <= tick_cnt + TICK_W'(1);
            end
        end
    end
`else
    logic [LED_W-3:0] st_code;

    assign st_code = (LED_W - 2)'(state);

    always_comb begin
        leds = {err, busy, st_code};
        if (state == S_SCAN) begin
            leds = res_q[LED_W-1:0];
        end else if (state == S_ERR) begin
            leds = '1;
        end
    end
`endif

endmodule

// File: tb/tb_matrix_op_sequencer.sv
// Scoreboard bench: expected op_start / RAM write / end-of-run events are queued by the stimulus
// and a negedge monitor pops and compares them as the DUT produces them.
`timescale 1ns/1ps
module tb_matrix_op_sequencer;

    localparam int DATA_W   = 256;
    localparam int ADDR_W   = 8;
    localparam int SIZE_W   = 3;
    localparam int LED_W    = 8;
    localparam int RD_LAT   = 1;
    localparam int TICK_DIV = 4;
    localparam int TIMEOUT  = 16;
    localparam int K_OPS    = 0;
    localparam int K_WR     = 1;
    localparam int K_END    = 2;
`ifdef MATSEQ_LED_SCAN_EN
    localparam bit SCAN_BUILD = 1'b1;
`else
    localparam bit SCAN_BUILD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              sw;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;
    logic [SIZE_W-1:0] op_size;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              op_start;
    logic              op_done;
    logic [DATA_W-1:0] op_result;
    logic              busy;
    logic              err;
    logic [LED_W-1:0]  leds;

    matrix_op_sequencer #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SIZE_W(SIZE_W), .LED_W(LED_W), .RD_LAT(RD_LAT),
        .TICK_DIV(TICK_DIV), .TIMEOUT(TIMEOUT), .SIZE_ADDR(0), .A_ADDR(1), .B_ADDR(2), .C_ADDR(3)
    ) dut (
        .clk(clk), .rst(rst), .sw(sw),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
        .op_size(op_size), .op_a(op_a), .op_b(op_b), .op_start(op_start),
        .op_done(op_done), .op_result(op_result),
        .busy(busy), .err(err), .leds(leds)
    );

    always #5 clk = ~clk;

    // RAM read model with one clock of latency; writes are observed by the monitor only.
    logic [DATA_W-1:0] mem [0:3];
    logic [DATA_W-1:0] rdata_q;
    always @(posedge clk) rdata_q <= (ram_addr < 8'd4) ? mem[ram_addr[1:0]] : '0;
    assign ram_rdata = rdata_q;

    // Coprocessor stub: op_done pulses done_delay cycles after the op_start cycle (0 = never).
    int                done_delay;
    int                cyc_since;
    logic [DATA_W-1:0] res_val;
    always @(posedge clk or posedge rst) begin
        if (rst)                                      cyc_since <= 0;
        else if (op_start)                            cyc_since <= 1;
        else if (cyc_since != 0 && cyc_since < 1000)  cyc_since <= cyc_since + 1;
    end
    assign op_done   = (done_delay != 0) && (cyc_since == done_delay);
    assign op_result = res_val;

    typedef struct {
        int                kind;
        logic [7:0]        addr;
        logic [DATA_W-1:0] d0;
        logic [DATA_W-1:0] d1;
        logic [SIZE_W-1:0] size;
        logic              e_err;
        logic [7:0]        e_leds;
        bit                chk_leds;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push(input int kind, input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                        input logic [SIZE_W-1:0] size, input logic e_err, input logic [7:0] e_leds,
                        input bit chk_leds);
        exp_t e;
        e.kind = kind; e.addr = 8'd3; e.d0 = d0; e.d1 = d1; e.size = size;
        e.e_err = e_err; e.e_leds = e_leds; e.chk_leds = chk_leds;
        q.push_back(e);
    endtask

    task automatic mon_event(input int kind);
        exp_t e;
        if (q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_event: got kind %0d expected no event", kind);
            return;
        end
        e = q.pop_front();
        check("event_kind", kind, e.kind);
        if (kind != e.kind) return;
        case (kind)
            K_OPS: begin
                check("op_size", op_size, e.size);
                check("op_a", op_a, e.d0);
                check("op_b", op_b, e.d1);
            end
            K_WR: begin
                check("wr_addr", ram_addr, e.addr);
                check("wr_data", ram_wdata, e.d0);
            end
            default: begin
                check("end_err", err, e.e_err);
                if (e.chk_leds) check("end_leds", leds, e.e_leds);
            end
        endcase
    endtask

    initial begin
        bit bprev;
        bprev = 1'b0;
        forever begin
            @(negedge clk);
            if (op_start)          mon_event(K_OPS);
            if (ram_we)            mon_event(K_WR);
            if (bprev && !busy)    mon_event(K_END);
            bprev = busy;
        end
    end

    function automatic logic [DATA_W-1:0] mk_res(input logic [7:0] base);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W / 8; i++) r[i*8 +: 8] = base + 8'(i);
        return r;
    endfunction

    // Leaves sw low long enough to clear the synchroniser, then raises it at a negedge (N0).
    task automatic sw_rise();
        sw = 1'b0;
        repeat (3) @(negedge clk);
        sw = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (!busy && k < 20)  begin @(negedge clk); k++; end
        while (busy && k < 400)  begin @(negedge clk); k++; end
        check(name, busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench time limit");
    end

    logic [DATA_W-1:0] a1, b1, a2, b2;
    int                exp_addr [6] = '{0, 0, 1, 1, 2, 2};

    initial begin
        int k;
        a1 = {8{32'hA1A1_0001}}; b1 = {8{32'hB1B1_0002}};
        a2 = {8{32'hA2A2_0003}}; b2 = {8{32'hB2B2_0004}};
        mem[0] = 256'd3; mem[1] = a1; mem[2] = b1; mem[3] = '0;
        rst = 1'b1; sw = 1'b0; done_delay = 0; res_val = mk_res(8'h01);

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_leds", leds, 8'h00);
        check("rst_op_start", op_start, 1'b0);
        check("rst_ram_we", ram_we, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_op_size", op_size, 3'd0);
        rst = 1'b0;

        // Reset while waiting for the coprocessor.
        push(K_OPS, a1, b1, 3'd3, 1'b0, 8'h00, 1'b0);
        push(K_END, '0, '0, '0, 1'b0, 8'h00, 1'b1);
        sw_rise();
        k = 0;
        while (!op_start && k < 50) begin @(negedge clk); k++; end
        check("midrun_op_start_seen", op_start, 1'b1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1; sw = 1'b0;
        @(negedge clk);
        check("midrun_rst_busy", busy, 1'b0);
        check("midrun_rst_leds", leds, 8'h00);
        check("midrun_rst_op_start", op_start, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("idle_after_reset", busy, 1'b0);

        // Nominal run: two clocks per read, one start pulse, one write.
        done_delay = 5;
        res_val = mk_res(8'h01);
        push(K_OPS, a1, b1, 3'd3, 1'b0, 8'h00, 1'b0);
        push(K_WR, res_val, '0, '0, 1'b0, 8'h00, 1'b0);
        push(K_END, '0, '0, '0, 1'b0, res_val[7:0], !SCAN_BUILD);
        sw_rise();
        @(negedge clk);
        check("sync_latency_busy", busy, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("read_addr", ram_addr, 8'(exp_addr[i]));
            check("read_busy", busy, 1'b1);
`ifndef MATSEQ_LED_SCAN_EN
            if (i == 0) check("busy_state_leds", leds, 8'h41);
`endif
        end
        @(negedge clk);
        check("op_start_timing", op_start, 1'b1);
        wait_idle("nominal_done");
        repeat (20) @(negedge clk);
        check("held_sw_no_restart", busy, 1'b0);
`ifndef MATSEQ_LED_SCAN_EN
        check("scan_static_leds", leds, 8'h01);
`endif

        // Restart from SCAN; a second start during RD_A must be ignored.
        mem[0] = 256'd5; mem[1] = a2; mem[2] = b2;
        res_val = mk_res(8'h40);
        push(K_OPS, a2, b2, 3'd5, 1'b0, 8'h00, 1'b0);
        push(K_WR, res_val, '0, '0, 1'b0, 8'h00, 1'b0);
        push(K_END, '0, '0, '0, 1'b0, 8'h40, !SCAN_BUILD);
        sw_rise();
        @(negedge clk);
        @(negedge clk);
        sw = 1'b0;
        @(negedge clk);
        sw = 1'b1;
        wait_idle("restart_done");

        // Coprocessor never answers: WAIT_DONE lasts TIMEOUT clocks, then ERR.
        mem[0] = 256'd2;
        done_delay = 0;
        push(K_OPS, a2, b2, 3'd2, 1'b0, 8'h00, 1'b0);
        push(K_END, '0, '0, '0, 1'b1, 8'hFF, 1'b1);
        sw_rise();
        k = 0;
        while (!op_start && k < 50) begin @(negedge clk); k++; end
        k = 0;
        while (!err && k < 100) begin @(negedge clk); k++; end
        check("timeout_cycles", k, TIMEOUT + 1);
        check("timeout_leds", leds, 8'hFF);
        check("timeout_busy", busy, 1'b0);
        repeat (5) @(negedge clk);

        // Restart from ERR with size 0: err clears, then ERR again without op_start.
        mem[0] = 256'd0;
        push(K_END, '0, '0, '0, 1'b1, 8'hFF, 1'b1);
        sw_rise();
        @(negedge clk);
        @(negedge clk);
        check("err_cleared_on_restart", err, 1'b0);
        check("size0_busy", busy, 1'b1);
        wait_idle("size0_done");
        repeat (5) @(negedge clk);

        // Done on the very last WAIT_DONE clock beats the timeout.
        mem[0] = 256'd1; mem[1] = a1; mem[2] = b1;
        done_delay = TIMEOUT;
        res_val = mk_res(8'h01);
        push(K_OPS, a1, b1, 3'd1, 1'b0, 8'h00, 1'b0);
        push(K_WR, res_val, '0, '0, 1'b0, 8'h00, 1'b0);
        push(K_END, '0, '0, '0, 1'b0, 8'h01, !SCAN_BUILD);
        sw_rise();
        wait_idle("done_wins_done");
        check("done_wins_err", err, 1'b0);
`ifdef MATSEQ_LED_SCAN_EN
        repeat (TICK_DIV) @(negedge clk);
        check("scan_tick1", leds, 8'h01);
        repeat (TICK_DIV) @(negedge clk);
        check("scan_tick2", leds, 8'h02);
        repeat (TICK_DIV * 31) @(negedge clk);
        check("scan_tick33_wrap", leds, 8'h01);
`endif

        repeat (5) @(negedge clk);
        check("scoreboard_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
